// File: rtl/sdf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdf_pkg
// Purpose  : Constants, twiddle ROM and modular arithmetic for the 64-point
//            mod-7681 SDF number-theoretic transform.
// Revision : 1.0
// ============================================================================
package sdf_pkg;

    localparam int Q     = 7681;
    localparam int N     = 64;
    localparam int LOG2N = 6;
    localparam int OMEGA = 5413;

    localparam int Q_W   = 13;
    localparam int TW_AW = LOG2N - 1;

    localparam logic [Q_W:0] Q_EXT = (Q_W + 1)'(Q);

    localparam int PROD_W    = 2 * Q_W;
    localparam int BARRETT_K = PROD_W;
    localparam int BARRETT_M = (1 << BARRETT_K) / Q;
    localparam int PM_W      = PROD_W + Q_W + 1;
    localparam int QH_W      = PM_W - BARRETT_K;

    // w^0 .. w^31 for w = OMEGA
    localparam logic [Q_W-1:0] TWIDDLE [0:N/2-1] = '{
        13'd1,    Q_W'(OMEGA), 13'd5235, 13'd1846, 13'd7098, 13'd1112, 13'd5033, 13'd6803,
        13'd1925, 13'd4589,    13'd7584, 13'd4928, 13'd6832, 13'd5282, 13'd2784, 13'd7351,
        13'd3383, 13'd675,     13'd5300, 13'd365,  13'd1728, 13'd5887, 13'd5543, 13'd2273,
        13'd6468, 13'd1286,    13'd2132, 13'd3654, 13'd527,  13'd3000, 13'd1366, 13'd5036
    };

    function automatic logic [Q_W-1:0] mod_add(input logic [Q_W-1:0] a, input logic [Q_W-1:0] b);
        logic [Q_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_EXT)
            s = s - Q_EXT;
        return Q_W'(s);
    endfunction

    function automatic logic [Q_W-1:0] mod_sub(input logic [Q_W-1:0] a, input logic [Q_W-1:0] b);
        logic [Q_W:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b)
            s = s + Q_EXT;
        return Q_W'(s);
    endfunction

    // Barrett with a full-width product: the quotient estimate is at most one
    // short, so a single conditional subtract lands in [0, q-1].
    function automatic logic [Q_W-1:0] mod_mul(input logic [Q_W-1:0] a, input logic [Q_W-1:0] b);
        logic [PROD_W-1:0] p;
        logic [PM_W-1:0]   pm;
        logic [QH_W-1:0]   qhat;
        logic [PROD_W-1:0] r;
        p    = {{Q_W{1'b0}}, a} * {{Q_W{1'b0}}, b};
        pm   = {{(PM_W-PROD_W){1'b0}}, p} * PM_W'(BARRETT_M);
        qhat = QH_W'(pm >> BARRETT_K);
        r    = p - PROD_W'(qhat) * PROD_W'(Q);
        if (r >= PROD_W'(Q))
            r = r - PROD_W'(Q);
        return Q_W'(r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdf_cu.sv
`default_nettype none
// ============================================================================
// Module   : sdf_cu
// Purpose  : Frame counter (one frame = 64 inputs + 64 outputs) and the
//            registered last-output pulse.
// Revision : 1.0
// ============================================================================
module sdf_cu #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    output logic [CNT_W-2:0] o_phase,
    output logic             o_done_tick
);

    localparam logic [CNT_W-1:0] c_pre_last = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [CNT_W-1:0] counter;

    // done_tick is registered alongside the counter so it equals (counter == max)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter     <= '0;
            o_done_tick <= 1'b0;
        end else if (i_enable) begin
            counter     <= counter + CNT_W'(1);
            o_done_tick <= (counter == c_pre_last);
        end
    end

    assign o_phase = counter[CNT_W-2:0];

endmodule
`default_nettype wire

// File: rtl/sdf_stage.sv
`default_nettype none
// ============================================================================
// Module   : sdf_stage
// Purpose  : One radix-2 DIF delay-feedback stage: DELAY-deep FIFO, butterfly
//            and twiddle selection.
// Revision : 1.0
// ============================================================================
module sdf_stage
    import sdf_pkg::*;
#(
    parameter int DELAY = 32,
    parameter int STAGE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_enable,
    input  logic [LOG2N-STAGE-1:0] i_phase,
    input  logic [Q_W-1:0]         i_data,
    output logic [Q_W-1:0]         o_data
);

    localparam int c_pw = LOG2N - STAGE;

    logic [Q_W-1:0]   r_fifo [DELAY];
    logic [Q_W-1:0]   w_head;
    logic [Q_W-1:0]   w_push;
    logic [TW_AW-1:0] w_tw_idx;
    logic             w_bfly;

    // Phase is counter mod 2*DELAY; the pipeline offset of every stage is a
    // multiple of 2*DELAY, so the shared counter bits can be used directly.
    assign w_head = r_fifo[DELAY-1];
    assign w_bfly = i_phase[c_pw-1];

    if (c_pw > 1) begin : g_tw_idx
        assign w_tw_idx = TW_AW'(i_phase[c_pw-2:0]) << STAGE;
    end else begin : g_tw_zero
        assign w_tw_idx = '0;
    end

    always_comb begin
        w_push = i_data;
        o_data = w_head;
        if (w_bfly) begin
            w_push = mod_mul(mod_sub(w_head, i_data), TWIDDLE[w_tw_idx]);
            o_data = mod_add(w_head, i_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++)
                r_fifo[i] <= '0;
        end else if (i_enable) begin
            r_fifo[0] <= w_push;
            for (int i = 1; i < DELAY; i++)
                r_fifo[i] <= r_fifo[i-1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdf_top.sv
`default_nettype none
// ============================================================================
// Module   : sdf_top
// Purpose  : 64-point mod-7681 DIF NTT, single-path delay feedback. Natural
//            order in, bit-reversed order out, one coefficient per clock.
// Revision : 1.0
// ============================================================================
module sdf_top
    import sdf_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MODULO     = 7681,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] sdf_in,
    output logic [DATA_WIDTH-1:0] sdf_out,
    output logic                  done_tick
);

    // Arithmetic and ROM are built for one fixed modulus and size
    if (MODULO != Q || ADDR_WIDTH != LOG2N) begin : g_bad_param
        $error("sdf_top supports only MODULO=7681 and ADDR_WIDTH=6");
    end

    logic [LOG2N-1:0]          w_phase;
    logic [LOG2N:0][Q_W-1:0]   w_chain;
    logic                      w_unused_in;

    assign w_chain[0]  = sdf_in[Q_W-1:0];
    assign w_unused_in = ^sdf_in[DATA_WIDTH-1:Q_W];

    sdf_cu #(
        .CNT_W (LOG2N + 1)
    ) cu_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (enable),
        .o_phase     (w_phase),
        .o_done_tick (done_tick)
    );

    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        sdf_stage #(
            .DELAY (N >> (s + 1)),
            .STAGE (s)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_enable (enable),
            .i_phase  (w_phase[LOG2N-1-s:0]),
            .i_data   (w_chain[s]),
            .o_data   (w_chain[s+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sdf_out <= '0;
        else if (enable)
            sdf_out <= DATA_WIDTH'(w_chain[LOG2N]);
    end

endmodule
`default_nettype wire

// File: tb/tb_sdf_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sdf_top
// Purpose  : Directed frames for sdf_top against hand values and a direct
//            O(N^2) NTT model; bit-reversed output order.
// Revision : 1.0
// ============================================================================
module tb_sdf_top;

    localparam int QM  = 7681;
    localparam int NPT = 64;

    logic        clk_tb = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [63:0] sdf_in;
    logic [63:0] sdf_out;
    logic        done_tick;

    int          n_checks = 0;
    int          n_pass   = 0;
    longint      pw    [NPT];
    logic [63:0] x_vec [NPT];
    logic [63:0] got   [NPT];
    logic [63:0] exp_o [NPT];

    always #5 clk_tb = ~clk_tb;

    sdf_top #(
        .DATA_WIDTH (64),
        .MODULO     (7681),
        .ADDR_WIDTH (6)
    ) dut (
        .clk       (clk_tb),
        .rst_n     (rst_n),
        .enable    (enable),
        .sdf_in    (sdf_in),
        .sdf_out   (sdf_out),
        .done_tick (done_tick)
    );

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int bitrev6(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 6; i++)
            if (v[i]) r = r | (1 << (5 - i));
        return r;
    endfunction

    function automatic void build_expected();
        longint acc;
        longint xk [NPT];
        for (int k = 0; k < NPT; k++) begin
            acc = 0;
            for (int n = 0; n < NPT; n++)
                acc = (acc + longint'(x_vec[n]) * pw[(n * k) % NPT]) % QM;
            xk[k] = acc;
        end
        for (int j = 0; j < NPT; j++)
            exp_o[j] = 64'(xk[bitrev6(j)]);
    endfunction

    // Drives one 128-cycle frame starting at a negedge with counter == 0
    task automatic run_frame(input string name, input bit gaps, input bit chk_done, input bit chk_zero);
        logic [63:0] held_out;
        logic        held_done;
        int          n_done;
        n_done = 0;
        check_value($sformatf("%s cnt_start", name), 64'(dut.cu_dut.counter), 64'd0);
        for (int c = 0; c < 128; c++) begin
            if (gaps && (c == 20 || c == 90 || c == 127)) begin
                held_out  = sdf_out;
                held_done = done_tick;
                enable    = 1'b0;
                sdf_in    = 64'd1234;
                repeat (5) @(negedge clk_tb);
                check_value($sformatf("%s gap%0d cnt", name, c), 64'(dut.cu_dut.counter), 64'(c));
                check_value($sformatf("%s gap%0d out", name, c), sdf_out, held_out);
                check_value($sformatf("%s gap%0d done", name, c), 64'(done_tick), 64'(held_done));
                enable = 1'b1;
            end
            if (c >= 64) got[c-64] = sdf_out;
            if (done_tick) n_done++;
            if (chk_done)
                check_value($sformatf("%s done@%0d", name, c), 64'(done_tick), 64'(c == 127));
            if (chk_zero && (c == 1 || c == 40 || c == 63))
                check_value($sformatf("%s zero@%0d", name, c), sdf_out, 64'd0);
            sdf_in = (c < 64) ? x_vec[c] : 64'((c * 97) % QM);
            @(negedge clk_tb);
        end
        if (!chk_done)
            check_value($sformatf("%s done_count", name), 64'(n_done), 64'd1);
        for (int j = 0; j < NPT; j++)
            check_value($sformatf("%s out%0d", name, j), got[j], exp_o[j]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [63:0] saved [NPT];
        rst_n  = 1'b0;
        enable = 1'b0;
        sdf_in = '0;
        pw[0]  = 1;
        for (int i = 1; i < NPT; i++)
            pw[i] = (pw[i-1] * 5413) % QM;

        repeat (3) @(negedge clk_tb);
        check_value("reset cnt", 64'(dut.cu_dut.counter), 64'd0);
        check_value("reset out", sdf_out, 64'd0);
        check_value("reset done", 64'(done_tick), 64'd0);
        rst_n  = 1'b1;
        enable = 1'b1;

        for (int n = 0; n < NPT; n++) begin
            x_vec[n] = (n == 0) ? 64'd1 : 64'd0;
            exp_o[n] = 64'd1;
        end
        run_frame("impulse", 1'b0, 1'b1, 1'b1);

        for (int n = 0; n < NPT; n++) begin
            x_vec[n] = 64'd1;
            exp_o[n] = (n == 0) ? 64'd64 : 64'd0;
        end
        run_frame("const1", 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < NPT; n++)
            x_vec[n] = (n == 1) ? 64'd1 : 64'd0;
        build_expected();
        run_frame("shift", 1'b0, 1'b0, 1'b0);
        check_value("shift hand0", got[0], 64'd1);
        check_value("shift hand1", got[1], 64'd7680);
        check_value("shift hand32", got[32], 64'd5413);
        check_value("shift hand16", got[16], 64'd5235);
        check_value("shift hand8", got[8], 64'd7098);

        for (int n = 0; n < NPT; n++) begin
            x_vec[n] = 64'd7680;
            exp_o[n] = (n == 0) ? 64'd7617 : 64'd0;
        end
        run_frame("allmax", 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < NPT; n++) begin
            x_vec[n] = 64'($urandom_range(0, QM - 1));
            saved[n] = x_vec[n];
        end
        x_vec[5]  = 64'd7680;
        saved[5]  = 64'd7680;
        build_expected();
        run_frame("rand1", 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < NPT; n++)
            x_vec[n] = 64'($urandom_range(0, QM - 1));
        build_expected();
        run_frame("rand2", 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < NPT; n++)
            x_vec[n] = saved[n];
        build_expected();
        run_frame("gaps", 1'b1, 1'b0, 1'b0);

        for (int c = 0; c < 40; c++) begin
            sdf_in = 64'($urandom_range(0, QM - 1));
            @(negedge clk_tb);
        end
        check_value("pre_rst cnt", 64'(dut.cu_dut.counter), 64'd40);
        rst_n = 1'b0;
        #1;
        check_value("mid_rst cnt", 64'(dut.cu_dut.counter), 64'd0);
        check_value("mid_rst out", sdf_out, 64'd0);
        check_value("mid_rst done", 64'(done_tick), 64'd0);
        repeat (2) @(negedge clk_tb);
        rst_n = 1'b1;

        for (int n = 0; n < NPT; n++)
            x_vec[n] = 64'($urandom_range(0, QM - 1));
        build_expected();
        run_frame("post_rst", 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdf_top.md
Name: sdf_top

Overview:
- 64-point radix-2 decimation-in-frequency (DIF) number-theoretic transform built as a single-path delay-feedback (SDF) pipeline, modulus 7681.
- Accepts one coefficient per clock in natural order. Streams out 64 transformed coefficients in bit-reversed order, one per clock.
- Sits in the polynomial-multiplication datapath between the coefficient source and the pointwise-multiply stage.

Parameters:
- data_width, 64: width of sdf_in/sdf_out. Only bits [12:0] are meaningful; outputs are zero-extended.
- modulo, 7681: prime modulus q.
- addr_width, 6: log2 of the transform size N; 6 pipeline stages; N = 64.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  clock enable; when low, all state is frozen.
- sdf_in  in  data_width  input coefficient, value < modulo.
- sdf_out  out  data_width  registered output coefficient.
- done_tick  out  1  one-cycle pulse marking the last output of a frame.

Behaviour:
- Transform: X[k] = sum over n of x[n]·w^(n·k) mod q, for k = 0..63. w = 5413 is a primitive 64th root of unity.
  - w^2=5235, w^4=7098, w^8=1925, w^16=3383, w^32=7680.
  - Cyclic NTT; no pre/post scaling.
- Control counter cu_dut.counter:
  - addr_width+1 bits (0..127); reset value 0.
  - Increments on each rising edge with enable=1; wraps 127→0.
  - Edge k of a frame (counter = k before the edge, k = 0..63) samples x[k] from sdf_in.
  - During counter 64..127, sdf_in is don't-care.
- Output timing:
  - After the edge that takes counter from 63+j to 64+j (j = 0..63), sdf_out = X[bitrev6(j)].
  - So sdf_out shows X[0] while counter=64, X[32] while counter=65, …, X[63] while counter=127.
  - After the wrap to 0, sdf_out is don't-care until the next frame's outputs.
- done_tick: high exactly while counter==127, i.e. during the last output's cycle; 0 otherwise.
- Stage s (s = 0..5), delay D = 32>>s, local index t = counter mod 2D:
  - t < D: the incoming sample is pushed into a D-deep FIFO. The stage outputs the FIFO head, which is the stored (a−b)·tw result from the previous block.
  - t ≥ D: a = FIFO head, b = incoming sample. Output = (a+b) mod q; push ((a−b) mod q)·w^((t−D)·2^s) mod q.
  - Stage timing is offset by the accumulated delay of the earlier stages.
- Butterflies are combinational. Only the FIFOs and the sdf_out register hold state. Total latency is 63 delay cycles plus the 1-cycle output register.
- Arithmetic:
  - Add and subtract are 14-bit with a single conditional ±q correction.
  - Multiply is 13×13 → 26 bits, fully reduced to [0, q−1] within the same cycle.
  - All outputs are strictly < q.
- Twiddle ROM: 32 entries holding w^0..w^31. Stage s uses index (t−D)<<s.
- Reset (async, any time, including mid-frame): counter, all FIFOs, sdf_out and done_tick → 0. The next frame starts at the first enabled edge after release.
- enable=0: counter, FIFOs, sdf_out and done_tick hold their values. A frame resumes unchanged when enable returns high.
- Back-to-back frames: the next frame's x[0] is sampled at the edge where counter = 0 after the wrap.

Decomposition:
- Package sdf_pkg holds: Q=7681, N=64, LOG2N=6, OMEGA=5413, the twiddle ROM constant array, and mod_add/mod_sub/mod_mul functions.
- Sub-module sdf_stage is instantiated 6× with parameters DELAY and STAGE. It contains the FIFO, the butterfly and the twiddle select.
- Control unit instance cu_dut holds the counter and done_tick logic.

Test Plan:
- Impulse: x[0]=1, others 0 → all 64 outputs = 1; done_tick high only during the 64th output cycle (counter=127).
- Constant: all x = 1 → first output (X[0]) = 64, remaining 63 outputs = 0.
- Shifted impulse: x[1]=1 → output j = w^bitrev6(j). Output 0 = 1, output 1 = 7680, output 32 = 5413.
- All x = 7680 → first output = 7617, rest 0. Then random vectors with values < 7681 compared against a software NTT in bit-reversed order.
- enable deasserted for 5 cycles at counter=20 and again at counter=90 → output sequence identical to the uninterrupted run; counter and done_tick frozen during the gaps.
- rst_n pulsed low at counter=40 → sdf_out=0, done_tick=0, counter=0 immediately. A full new frame then produces correct results.
